// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads, and holds a
// 1-entry skid so a stall never loses a returning word. Define FETCH_PERF_CNT_EN for fetch/bubble counters.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  IMEM_ADDR_W = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            bubble_count
`endif
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                infl_q, infl_d;
  logic [PC_WIDTH-1:0] infl_pc_q, infl_pc_d;
  logic                skid_v_q, skid_v_d;
  logic [31:0]         skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                out_v_q, out_v_d;
  logic                load, bubble;

  assign imem_en     = rst & ~stall & ~redirect;
  assign imem_addr   = pc_q[IMEM_ADDR_W+1:2];
  assign instr       = out_instr_q;
  assign instr_pc    = out_pc_q;
  assign instr_valid = out_v_q;

  logic unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];

  always_comb begin
    pc_d         = pc_q;
    infl_d       = imem_en;
    infl_pc_d    = infl_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_v_d      = out_v_q;
    load         = 1'b0;
    bubble       = 1'b0;
    if (redirect) begin
      // Squash everything in flight, including the skid entry.
      pc_d     = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      skid_v_d = 1'b0;
      out_v_d  = 1'b0;
      bubble   = ~stall;
    end else if (stall) begin
      if (infl_q) begin
        skid_v_d     = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d    = infl_pc_q;
      end
    end else begin
      pc_d      = pc_q + PC_WIDTH'(4);
      infl_pc_d = pc_q;
      if (skid_v_q) begin
        out_instr_d = skid_instr_q;
        out_pc_d    = skid_pc_q;
        out_v_d     = 1'b1;
        skid_v_d    = 1'b0;
        load        = 1'b1;
      end else if (infl_q) begin
        out_instr_d = imem_rdata;
        out_pc_d    = infl_pc_q;
        out_v_d     = 1'b1;
        load        = 1'b1;
      end else begin
        out_v_d = 1'b0;
        bubble  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      infl_q       <= 1'b0;
      infl_pc_q    <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_v_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      infl_q       <= infl_d;
      infl_pc_q    <= infl_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_v_q      <= out_v_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (load)   fetch_count  <= fetch_count + 32'd1;
      if (bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = load ^ bubble;
`endif

endmodule
